// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the parameterised RAM slice: default geometry
// constants, the clear-controller state type and a helper that turns a
// word count into an index width.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 256;

    // CLEAR walks the array writing zeros, READY serves normal traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ctrlStateT;

    // Index width for a power-of-two depth; a depth of one still needs a
    // one-bit index so that no zero-width vectors appear.
    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// -----------------------------------------------------------------------------
// mem_clear_ctrl
// Clear sequencer for param_ram. After reset it steps an index from 0 to
// DEPTH-1, one word per clock, asking the RAM to write zero at each index,
// then parks in READY until the next reset.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset, restarts the clear from 0
//   busy     - high for every cycle spent in CLEAR
//   clearIdx - word index to zero this cycle
//   clearWe  - write strobe for the zero write at clearIdx
// -----------------------------------------------------------------------------
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = idxWidth(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    output logic [IDX_W-1:0] clearIdx,
    output logic             clearWe
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    ctrlStateT        state;
    ctrlStateT        nextState;
    logic [IDX_W-1:0] nextIdx;

    // State and index registers; reset always returns to the start of a
    // full clear, whether it arrives mid-clear or while READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clearIdx <= '0;
        end else begin
            state    <= nextState;
            clearIdx <= nextIdx;
        end
    end

    // Next-state logic: the last zero write happens in the same cycle that
    // decides to leave CLEAR, so busy lasts exactly DEPTH cycles.
    always_comb begin
        nextState = state;
        nextIdx   = clearIdx;
        busy      = 1'b0;
        clearWe   = 1'b0;
        unique case (state)
            CLEAR: begin
                busy    = 1'b1;
                clearWe = 1'b1;
                if (clearIdx == LAST_IDX) begin
                    nextState = READY;
                    nextIdx   = '0;
                end else begin
                    nextIdx = clearIdx + IDX_W'(1);
                end
            end
            READY: begin
                nextState = READY;
            end
            default: begin
                nextState = CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/param_ram.sv
// -----------------------------------------------------------------------------
// param_ram
// Word-addressed RAM with one byte-maskable write port, a registered data
// read and a registered double-word instruction fetch. Reads are write-first:
// a read of a word written in the same cycle returns the merged new value.
// After reset the whole array is zeroed through the normal write port while
// busy is high; all requests are ignored during that time.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   dataAddr            - data word address (taken modulo DEPTH)
//   inData, byte_en     - write data and per-byte write mask
//   write_en            - write request at dataAddr
//   data_rd_en          - data read request at dataAddr
//   instAddr, inst_rd_en- instruction fetch address and request
//   dataOut, data_valid - registered read result and its one-cycle flag
//   instOut, inst_valid - {mem[a], mem[a+1]} and its one-cycle flag
//   busy                - array is being cleared
// -----------------------------------------------------------------------------
module param_ram
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   dataAddr,
    input  logic [DATA_W-1:0]   inData,
    input  logic                write_en,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                data_rd_en,
    input  logic [ADDR_W-1:0]   instAddr,
    input  logic                inst_rd_en,
    output logic [DATA_W-1:0]   dataOut,
    output logic                data_valid,
    output logic [2*DATA_W-1:0] instOut,
    output logic                inst_valid,
    output logic                busy
);

    localparam int IDX_W = idxWidth(DEPTH);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busyInt;
    logic [IDX_W-1:0]  clearIdx;
    logic              clearWe;
    logic [IDX_W-1:0]  dIdx;
    logic [IDX_W-1:0]  iIdxHi;
    logic [IDX_W-1:0]  iIdxLo;
    logic              wrEn;
    logic [IDX_W-1:0]  wrIdx;
    logic [DATA_W-1:0] wrWord;
    logic [DATA_W-1:0] mergedWord;
    logic [DATA_W-1:0] dReadWord;
    logic [DATA_W-1:0] iHiWord;
    logic [DATA_W-1:0] iLoWord;
    logic              dataReq;
    logic              instReq;
    logic              unusedAddr;

    mem_clear_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) uClearCtrl (
        .clk      (clk),
        .rst      (rst),
        .busy     (busyInt),
        .clearIdx (clearIdx),
        .clearWe  (clearWe)
    );

    assign busy = busyInt;

    // Address upper bits are dropped so addresses wrap modulo DEPTH; the
    // second fetch word wraps the same way from the last index back to 0.
    assign dIdx       = dataAddr[IDX_W-1:0];
    assign iIdxHi     = instAddr[IDX_W-1:0];
    assign iIdxLo     = iIdxHi + IDX_W'(1);
    assign unusedAddr = ^{dataAddr, instAddr};

    assign dataReq = data_rd_en && !busyInt;
    assign instReq = inst_rd_en && !busyInt;

    // Byte merge of the incoming write over the current contents.
    always_comb begin
        mergedWord = mem[dIdx];
        for (int b = 0; b < BYTES; b++) begin
            if (byte_en[b]) begin
                mergedWord[8*b +: 8] = inData[8*b +: 8];
            end
        end
    end

    // Single write port shared by the clear sequence and user writes. The
    // clear owns the port while busy; reset blocks every write that cycle.
    // An all-zero byte mask is treated as no write at all.
    always_comb begin
        wrEn   = 1'b0;
        wrIdx  = clearIdx;
        wrWord = '0;
        if (!rst) begin
            if (clearWe) begin
                wrEn = 1'b1;
            end else if (write_en && (byte_en != '0)) begin
                wrEn   = 1'b1;
                wrIdx  = dIdx;
                wrWord = mergedWord;
            end
        end
    end

    // Write-first forwarding: any read index that matches the word being
    // written this cycle sees the new value instead of the stale array word.
    always_comb begin
        dReadWord = (wrEn && (wrIdx == dIdx))   ? wrWord : mem[dIdx];
        iHiWord   = (wrEn && (wrIdx == iIdxHi)) ? wrWord : mem[iIdxHi];
        iLoWord   = (wrEn && (wrIdx == iIdxLo)) ? wrWord : mem[iIdxLo];
    end

    // Storage array; deliberately no reset here, zeroing is done by the
    // clear sequence through the write port.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrIdx] <= wrWord;
        end
    end

    // Output registers: results update only on an accepted read and are
    // otherwise held, while the valid flags pulse for a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut    <= '0;
            instOut    <= '0;
            data_valid <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            data_valid <= dataReq;
            inst_valid <= instReq;
            if (dataReq) begin
                dataOut <= dReadWord;
            end
            if (instReq) begin
                instOut <= {iHiWord, iLoWord};
            end
        end
    end

endmodule

// File: tb/tb_param_ram.sv
// -----------------------------------------------------------------------------
// tb_param_ram
// Directed bench for param_ram with default geometry (16-bit words, 256
// words). A reference memory predicts read results, which are queued when a
// request is driven and popped when the matching valid flag is seen.
// -----------------------------------------------------------------------------
module tb_param_ram;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] dataAddr;
    logic [DATA_W-1:0] inData;
    logic              write_en;
    logic [1:0]        byte_en;
    logic              data_rd_en;
    logic [ADDR_W-1:0] instAddr;
    logic              inst_rd_en;
    logic [DATA_W-1:0] dataOut;
    logic              data_valid;
    logic [31:0]       instOut;
    logic              inst_valid;
    logic              busy;

    logic [15:0] modelMem [DEPTH];
    logic [15:0] dataQ [$];
    logic [31:0] instQ [$];
    logic [15:0] heldData;
    logic [31:0] heldInst;
    logic        expDataValid;
    logic        expInstValid;
    int          clearLeft;
    int          checks;
    int          failures;

    param_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dataAddr   (dataAddr),
        .inData     (inData),
        .write_en   (write_en),
        .byte_en    (byte_en),
        .data_rd_en (data_rd_en),
        .instAddr   (instAddr),
        .inst_rd_en (inst_rd_en),
        .dataOut    (dataOut),
        .data_valid (data_valid),
        .instOut    (instOut),
        .inst_valid (inst_valid),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against the prediction for the edge just taken.
    task automatic checkOutput(input string tag);
        checkVal({tag, ".busy"}, {31'd0, busy}, {31'd0, (clearLeft != 0)});
        checkVal({tag, ".data_valid"}, {31'd0, data_valid}, {31'd0, expDataValid});
        checkVal({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, expInstValid});
        if (expDataValid) begin
            if (dataQ.size() > 0) heldData = dataQ.pop_front();
        end
        if (expInstValid) begin
            if (instQ.size() > 0) heldInst = instQ.pop_front();
        end
        checkVal({tag, ".dataOut"}, {16'd0, dataOut}, {16'd0, heldData});
        checkVal({tag, ".instOut"}, instOut, heldInst);
    endtask

    // Drive one cycle of inputs, update the reference model (write first,
    // then reads so same-cycle reads see the new data), take the edge and
    // check the outputs 1 unit later.
    task automatic applyStimulus(input logic rstIn, input logic we, input logic [1:0] be,
                                 input logic [15:0] dAddr, input logic [15:0] din,
                                 input logic drd, input logic [15:0] iAddr,
                                 input logic ird, input string tag);
        int dI;
        int iI;
        rst        = rstIn;
        write_en   = we;
        byte_en    = be;
        dataAddr   = dAddr;
        inData     = din;
        data_rd_en = drd;
        instAddr   = iAddr;
        inst_rd_en = ird;
        dI = int'(dAddr[7:0]);
        iI = int'(iAddr[7:0]);
        if (rstIn) begin
            clearLeft    = DEPTH;
            heldData     = '0;
            heldInst     = '0;
            expDataValid = 1'b0;
            expInstValid = 1'b0;
            for (int k = 0; k < DEPTH; k++) modelMem[k] = '0;
        end else if (clearLeft > 0) begin
            clearLeft--;
            expDataValid = 1'b0;
            expInstValid = 1'b0;
        end else begin
            if (we) begin
                if (be[0]) modelMem[dI][7:0]  = din[7:0];
                if (be[1]) modelMem[dI][15:8] = din[15:8];
            end
            if (drd) dataQ.push_back(modelMem[dI]);
            if (ird) instQ.push_back({modelMem[iI], modelMem[(iI + 1) % DEPTH]});
            expDataValid = drd;
            expInstValid = ird;
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Directed sequence covering clear timing, latency, masking, wrap and
    // write-first behaviour, then a reset in the middle of a clear.
    initial begin
        checks    = 0;
        failures  = 0;
        clearLeft = 0;
        heldData  = '0;
        heldInst  = '0;

        applyStimulus(1, 1, 2'b11, 16'd0, 16'hFFFF, 1, 16'd0, 1, "reset");
        for (int k = 0; k < DEPTH; k++)
            applyStimulus(0, 1, 2'b11, 16'd20, 16'hBEEF, 1, 16'd21, 1, "clearIgnored");

        applyStimulus(0, 0, 2'b00, 16'd10, 16'h0000, 1, 16'd0, 0, "readAfterClear");
        checkVal("readAfterClear.const", {16'd0, dataOut}, 32'h0);
        applyStimulus(0, 0, 2'b00, 16'd20, 16'h0000, 1, 16'd0, 0, "busyWriteDropped");

        applyStimulus(0, 1, 2'b11, 16'd10, 16'd3, 0, 16'd0, 0, "write10");
        applyStimulus(0, 1, 2'b11, 16'd12, 16'd4, 0, 16'd0, 0, "write12");
        applyStimulus(0, 1, 2'b11, 16'd14, 16'd5, 0, 16'd0, 0, "write14");
        applyStimulus(0, 1, 2'b11, 16'd16, 16'd6, 0, 16'd0, 0, "write16");
        applyStimulus(0, 0, 2'b00, 16'd10, 16'd0, 1, 16'd0, 0, "read10");
        checkVal("read10.const", {16'd0, dataOut}, 32'd3);
        applyStimulus(0, 0, 2'b00, 16'd14, 16'd0, 1, 16'd0, 0, "read14");
        checkVal("read14.const", {16'd0, dataOut}, 32'd5);
        applyStimulus(0, 0, 2'b00, 16'd0, 16'd0, 0, 16'd0, 0, "idleHold");

        applyStimulus(0, 1, 2'b11, 16'd10, 16'h1234, 0, 16'd0, 0, "write1234");
        applyStimulus(0, 1, 2'b01, 16'd10, 16'hABCD, 0, 16'd0, 0, "writeLowByte");
        applyStimulus(0, 0, 2'b00, 16'd10, 16'd0, 1, 16'd0, 0, "readMerged");
        checkVal("readMerged.const", {16'd0, dataOut}, 32'h12CD);

        applyStimulus(0, 1, 2'b10, 16'd30, 16'h5555, 1, 16'd0, 0, "writeFirstData");
        applyStimulus(0, 1, 2'b00, 16'd12, 16'hFFFF, 1, 16'd0, 0, "zeroMaskRead");
        checkVal("zeroMaskRead.const", {16'd0, dataOut}, 32'd4);

        applyStimulus(0, 1, 2'b11, 16'd0, 16'd9, 0, 16'd0, 0, "write0");
        applyStimulus(0, 1, 2'b11, 16'd255, 16'd7, 1, 16'd255, 1, "wrapFetch");
        checkVal("wrapFetch.const", instOut, 32'h00070009);
        applyStimulus(0, 0, 2'b00, 16'd266, 16'd0, 1, 16'd0, 0, "aliasRead266");
        checkVal("aliasRead266.const", {16'd0, dataOut}, 32'h12CD);

        applyStimulus(0, 1, 2'b11, 16'd41, 16'h0077, 0, 16'd40, 1, "writeFirstInstLo");
        applyStimulus(0, 1, 2'b11, 16'd40, 16'h0088, 1, 16'd40, 1, "writeFirstInstHi");
        applyStimulus(0, 0, 2'b00, 16'd0, 16'd0, 0, 16'd0, 0, "idleHoldInst");

        applyStimulus(1, 1, 2'b11, 16'd20, 16'hBEEF, 1, 16'd20, 1, "reset2");
        for (int k = 0; k < 100; k++)
            applyStimulus(0, 1, 2'b11, 16'd20, 16'hBEEF, 1, 16'd20, 1, "partialClear");
        applyStimulus(1, 1, 2'b11, 16'd20, 16'hBEEF, 1, 16'd20, 1, "resetMidClear");
        for (int k = 0; k < DEPTH; k++)
            applyStimulus(0, 1, 2'b11, 16'd20, 16'hBEEF, 1, 16'd20, 1, "reClear");
        applyStimulus(0, 0, 2'b00, 16'd10, 16'd0, 1, 16'd255, 1, "readAfterReClear");
        checkVal("readAfterReClear.const", {16'd0, dataOut}, 32'h0);
        applyStimulus(0, 0, 2'b00, 16'd20, 16'd0, 1, 16'd0, 0, "reClearDropped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
